// File: rtl/gpi_debounce_pkg.sv
// Shared types for the general-purpose input debouncer.
//
// Contents:
//   deb_state_e : per-bit filter state
//                 StIdle  - synchronised input agrees with the accepted level
//                 StCount - input disagrees; counting consecutive disagreeing cycles
//   cnt_width() : width of the per-bit disagreement counter for a given cycle count
package gpi_debounce_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StCount = 1'b1
  } deb_state_e;

  // Counter must hold values up to DebounceCycles - 1. Sizing for DebounceCycles + 1
  // keeps the width at least one bit when DebounceCycles == 1.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpi_debounce_bit.sv
// Single-bit input conditioner: two-flop synchroniser, disagreement counter and
// acceptance state machine producing a clean level plus one-cycle edge pulses.
//
// Ports:
//   clk_sys_i    : system clock
//   rst_sys_ni   : asynchronous active-low reset
//   raw_i        : raw pad input, asynchronous to clk_sys_i
//   stable_o     : debounced level (registered)
//   rise_o       : one-cycle pulse when a 0->1 change is accepted (registered)
//   fall_o       : one-cycle pulse when a 1->0 change is accepted (registered)
//   rise_next_o  : next-state value of rise_o, lets the parent register an OR alongside
//   fall_next_o  : next-state value of fall_o
module gpi_debounce_bit
  import gpi_debounce_pkg::*;
#(
  parameter int unsigned DebounceCycles = 4,
  parameter logic        ResetValue     = 1'b0
) (
  input  logic clk_sys_i,
  input  logic rst_sys_ni,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o,
  output logic rise_next_o,
  output logic fall_next_o
);

  localparam int unsigned CntW = cnt_width(DebounceCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic            sync1_q, sync2_q;
  deb_state_e      state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            stable_d, stable_q;
  logic            rise_d, rise_q;
  logic            fall_d, fall_q;

  // Plain flop chain, nothing between the stages, to give the first flop a full
  // cycle to resolve metastability.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sync1_q <= ResetValue;
      sync2_q <= ResetValue;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (sync2_q != stable_q) begin
          if (DebounceCycles == 1) begin
            // No filtering window: the first disagreeing cycle is accepted.
            stable_d = sync2_q;
            rise_d   = sync2_q;
            fall_d   = ~sync2_q;
          end else begin
            state_d = StCount;
            cnt_d   = CntOne;
          end
        end
      end
      StCount: begin
        if (sync2_q == stable_q) begin
          // Bounced back before the window expired: drop progress silently.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d  = StIdle;
          cnt_d    = '0;
          stable_d = sync2_q;
          rise_d   = sync2_q;
          fall_d   = ~sync2_q;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      stable_q <= ResetValue;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_o    = stable_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign rise_next_o = rise_d;
  assign fall_next_o = fall_d;

endmodule

// File: rtl/gpi_debounce.sv
// General-purpose input conditioning: Width independent synchronise-and-debounce
// channels feeding the system GPI bus, plus aggregated change indication.
//
// Parameters:
//   Width          : number of independent input bits
//   DebounceCycles : consecutive disagreeing cycles needed to accept a new level (>= 1)
//   ResetValue     : reset value of synchroniser flops and stable_o, per bit
//
// Ports:
//   clk_sys_i  : system clock
//   rst_sys_ni : asynchronous active-low reset
//   raw_i      : raw pad inputs, asynchronous to clk_sys_i
//   stable_o   : debounced levels
//   rise_o     : per-bit one-cycle pulse on accepted 0->1
//   fall_o     : per-bit one-cycle pulse on accepted 1->0
//   change_o   : OR of all rise_o/fall_o bits, asserted in the same cycle as them
module gpi_debounce
  import gpi_debounce_pkg::*;
#(
  parameter int unsigned          Width          = 8,
  parameter int unsigned          DebounceCycles = 500_000,
  parameter logic [Width-1:0]     ResetValue     = '0
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [Width-1:0] raw_i,
  output logic [Width-1:0] stable_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             change_o
);

  if (DebounceCycles < 1) begin : g_bad_cycles
    $error("gpi_debounce: DebounceCycles must be >= 1");
  end

  logic [Width-1:0] rise_next;
  logic [Width-1:0] fall_next;
  logic             change_d, change_q;

  for (genvar i = 0; i < Width; i++) begin : g_bit
    gpi_debounce_bit #(
      .DebounceCycles (DebounceCycles),
      .ResetValue     (ResetValue[i])
    ) u_bit (
      .clk_sys_i   (clk_sys_i),
      .rst_sys_ni  (rst_sys_ni),
      .raw_i       (raw_i[i]),
      .stable_o    (stable_o[i]),
      .rise_o      (rise_o[i]),
      .fall_o      (fall_o[i]),
      .rise_next_o (rise_next[i]),
      .fall_next_o (fall_next[i])
    );
  end

  // Built from the per-bit next-state pulses so the registered OR lines up with
  // the registered rise/fall outputs.
  always_comb begin
    change_d = |(rise_next | fall_next);
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      change_q <= 1'b0;
    end else begin
      change_q <= change_d;
    end
  end

  assign change_o = change_q;

endmodule

// File: tb/tb_gpi_debounce.sv
// Scoreboard bench for gpi_debounce (Width=4, DebounceCycles=4, ResetValue=4'b0001).
// Stimulus pushes expected acceptance events (level, pulses, edge number) into a queue;
// the monitor pops one whenever change_o is seen and otherwise checks that outputs hold.
module tb_gpi_debounce;

  localparam int unsigned W  = 4;
  localparam int unsigned DC = 4;
  localparam logic [W-1:0] RV = 4'b0001;

  typedef struct {
    logic [W-1:0] stable;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    int           cyc;
  } exp_t;

  logic         clk_sys;
  logic         rst_sys_n;
  logic [W-1:0] raw;
  logic [W-1:0] stable;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         change;

  exp_t         exp_q[$];
  logic [W-1:0] exp_stable;
  int           cyc;
  int           compared;
  int           failed;

  gpi_debounce #(
    .Width          (W),
    .DebounceCycles (DC),
    .ResetValue     (RV)
  ) u_dut (
    .clk_sys_i  (clk_sys),
    .rst_sys_ni (rst_sys_n),
    .raw_i      (raw),
    .stable_o   (stable),
    .rise_o     (rise),
    .fall_o     (fall),
    .change_o   (change)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s at edge %0d: got %0h required %0h", name, cyc, act, req);
    end
  endtask

  // Acceptance expected at edge (current edge + dly); called at a negedge.
  task automatic expect_event(input logic [W-1:0] s, input logic [W-1:0] r,
                              input logic [W-1:0] f, input int dly);
    exp_t e;
    e.stable = s;
    e.rise   = r;
    e.fall   = f;
    e.cyc    = cyc + dly;
    exp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Monitor: samples 1 time unit after each active edge.
  initial begin
    exp_t e;
    exp_stable = RV;
    forever begin
      @(posedge clk_sys);
      #1;
      if (!rst_sys_n) begin
        exp_stable = RV;
        check("reset_stable", 32'(stable), 32'(RV));
        check("reset_pulses", {29'd0, change, 1'b0, |rise, |fall}, 32'd0);
      end else if (change) begin
        if (exp_q.size() == 0) begin
          check("unexpected_change", 32'(stable), 32'(exp_stable));
          check("unexpected_change_pulse", 32'(rise | fall), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("event_edge", 32'(cyc), 32'(e.cyc));
          check("event_stable", 32'(stable), 32'(e.stable));
          check("event_rise", 32'(rise), 32'(e.rise));
          check("event_fall", 32'(fall), 32'(e.fall));
          exp_stable = e.stable;
        end
      end else begin
        check("idle_stable", 32'(stable), 32'(exp_stable));
        check("idle_pulses", 32'(rise | fall), 32'd0);
      end
    end
  end

  initial begin
    compared  = 0;
    failed    = 0;
    rst_sys_n = 1'b0;
    raw       = 4'b1111;

    // Reset held with raw differing from ResetValue: no pulse, outputs at ResetValue.
    wait_cycles(3);
    raw       = 4'b0001;
    rst_sys_n = 1'b1;
    wait_cycles(4);

    // Single rising bit.
    raw = 4'b0011;
    expect_event(4'b0011, 4'b0010, 4'b0000, DC + 2);
    wait_cycles(10);

    // Three-cycle glitch on bit 2: rejected.
    raw = 4'b0111;
    wait_cycles(3);
    raw = 4'b0011;
    wait_cycles(10);

    // Simultaneous fall on bit 0 and rise on bit 3.
    raw = 4'b1010;
    expect_event(4'b1010, 4'b1000, 4'b0001, DC + 2);
    wait_cycles(10);

    // Settle bit 1 low.
    raw = 4'b1000;
    expect_event(4'b1000, 4'b0000, 4'b0010, DC + 2);
    wait_cycles(10);

    // Bit 1 bounce: high 2, low 1, then high held; counting restarts at the last rise.
    raw = 4'b1010;
    wait_cycles(2);
    raw = 4'b1000;
    wait_cycles(1);
    raw = 4'b1010;
    expect_event(4'b1010, 4'b0010, 4'b0000, DC + 2);
    wait_cycles(12);

    // Bit 2 toggling every cycle: never accepted.
    for (int i = 0; i < 20; i++) begin
      raw[2] = ~raw[2];
      wait_cycles(1);
    end
    wait_cycles(8);

    // Reset while bit 2 counter is at 2, then release with raw unchanged.
    raw = 4'b1110;
    wait_cycles(4);
    rst_sys_n = 1'b0;
    wait_cycles(2);
    rst_sys_n = 1'b1;
    expect_event(4'b1110, 4'b1110, 4'b0001, DC + 2);
    wait_cycles(12);

    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      compared++;
      failed++;
      $display("FAIL missing_event: no change_o seen, required stable %0h at edge %0d",
               e.stable, e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/gpi_debounce.md
Name: gpi_debounce

Overview:
- Input-conditioning stage between the board switches/buttons and the demo system's general-purpose input bus.
- Per bit: synchronises the raw asynchronous pad input into the system clock domain, filters contact bounce, and produces a clean level plus single-cycle rise/fall pulses.
- Output `stable_o` drives the system's GPI input directly.
- `rise_o`/`fall_o`/`change_o` are available for interrupt or event logic.

Parameters:
- Width, 8, number of independent input bits.
- DebounceCycles, 500_000, consecutive disagreeing cycles required before a level is accepted (10 ms at 50 MHz). Must be >= 1; elaboration error otherwise.
- ResetValue, '0 (Width bits), reset value of synchroniser flops and `stable_o`, per bit.

Ports:
- clk_sys_i  input  1  system clock
- rst_sys_ni  input  1  reset, asynchronous assert, active-low
- raw_i  input  Width  raw pad inputs, asynchronous to clk_sys_i
- stable_o  output  Width  debounced level
- rise_o  output  Width  one-cycle pulse per bit on accepted 0->1
- fall_o  output  Width  one-cycle pulse per bit on accepted 1->0
- change_o  output  1  OR of all rise_o and fall_o bits, registered with them (same cycle)

Behaviour:
- Reset (async, `rst_sys_ni` low):
  - sync1/sync2 = ResetValue; stable_o = ResetValue.
  - rise_o = fall_o = 0; change_o = 0.
  - All counters = 0; all bits in state IDLE.
- Synchroniser: 2-flop chain per bit (raw_i -> sync1 -> sync2). No logic between the flops.
- Per-bit state machine, evaluated each clock edge:
  - IDLE (sync2 == stable):
    - cnt held at 0.
    - If sync2 != stable, go to COUNT with cnt = 1 when DebounceCycles > 1.
    - If DebounceCycles == 1, accept immediately and stay in IDLE.
  - COUNT:
    - If sync2 == stable (bounce back): cnt = 0, return to IDLE, no pulse.
    - Else if cnt == DebounceCycles-1: stable = sync2, pulse, cnt = 0, go to IDLE.
    - Else cnt++.
- Counter width: $clog2(DebounceCycles+1). cnt never exceeds DebounceCycles-1, so there is no wrap.
- Acceptance pulse:
  - rise_o[i] = 1 (new value 1) or fall_o[i] = 1 (new value 0) for exactly one cycle.
  - The pulse is asserted in the same cycle stable_o[i] first shows the new value.
  - change_o is registered in that same cycle.
- Latency: raw held steady from clock edge k onward -> stable_o updates at edge k+1+DebounceCycles, i.e. DebounceCycles+2 edges counting edge k.
- Glitch rejection: any disagreement window shorter than DebounceCycles cycles at sync2 produces no output change and no pulse.
- Bits are fully independent. Simultaneous acceptances on several bits pulse in the same cycle; change_o is asserted once.
- Reset mid-count: discards progress. After release, bits restart from ResetValue in IDLE. No pulse is generated on reset release, even if raw_i differs from ResetValue; that difference is then debounced normally.
- raw_i toggling every cycle: never accepted, outputs static.

Decomposition:
- Package gpi_debounce_pkg: state enum (IDLE, COUNT).
- Sub-module gpi_debounce_bit: one synchroniser, one counter, one state machine, stable/rise/fall.
- The top generate-loops gpi_debounce_bit Width times and ORs the pulses into change_o.

Test Plan (Width=4, DebounceCycles=4, ResetValue=4'b0001):
- Reset -> stable_o=0001, rise/fall/change=0. Assert reset for 3 cycles with raw_i=1111 -> outputs still 0001, no pulse.
- After reset, raw_i[1] 0->1 held, applied before edge k -> at edge k+5 stable_o=0011, rise_o=0010 and change_o=1 for exactly one cycle, fall_o=0.
- raw_i[2] high for 3 cycles, then low -> stable_o unchanged, no pulses.
- raw_i[0] 1->0 and raw_i[3] 0->1 in the same cycle, held -> both update at the same edge; fall_o=0001, rise_o=1000, change_o=1 for one cycle.
- raw_i[1] bouncing (high 2 cycles, low 1 cycle, high held) -> counter restarts; stable_o[1] rises 6 edges after the final rising transition is captured, single rise pulse.
- Assert reset when cnt=2 during COUNT -> outputs return to ResetValue, no pulse. After release with raw_i unchanged, acceptance occurs a full DebounceCycles+2 edges later.
